// File: rtl/pwr_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwr_seq_pkg
// Shared definitions for the rail power sequencer and its step timer.
//   seq_state_t   : sequencer states ST_IDLE .. ST_FAULT
//   delay_cycles(): converts a delay in ns to a clock-cycle count, floor or
//                   ceil, never less than one cycle. Shared with other timer
//                   blocks that need the same conversion.
// -----------------------------------------------------------------------------
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    // round = 0 -> floor(period/cycle), round != 0 -> ceil(period/cycle).
    // A zero result would make a step vanish, so it is clamped to one cycle.
    function automatic int delay_cycles(input int period, input int cycle, input int round);
        int d;
        if (cycle <= 0) begin
            d = 1;
        end else if (round != 0) begin
            d = (period + cycle - 1) / cycle;
        end else begin
            d = period / cycle;
        end
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// -----------------------------------------------------------------------------
// seq_step_timer
// One-shot step timer. A start sampled high at edge S (re)arms the counter;
// done is high for exactly one cycle, visible at edge S+DELAY_CYCLE. A start
// while running restarts the count from scratch.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : restart request, sampled every edge
//   done   : one-cycle pulse DELAY_CYCLE cycles after start
// -----------------------------------------------------------------------------
module seq_step_timer #(
    parameter int DELAY_CYCLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int CW = $clog2(DELAY_CYCLE + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLE);

    logic [CW-1:0] count_reg;
    logic          running_reg;

    // The count starts at 1 on the start edge so that done decodes directly
    // from the registers and lands on edge S+D even when D is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            count_reg   <= CNT_ONE;
            running_reg <= 1'b1;
        end else if (running_reg) begin
            if (count_reg == CNT_LAST) begin
                running_reg <= 1'b0;
            end else begin
                count_reg <= count_reg + CNT_ONE;
            end
        end
    end

    assign done = running_reg && (count_reg == CNT_LAST);

endmodule

// File: rtl/rail_power_sequencer.sv
// -----------------------------------------------------------------------------
// rail_power_sequencer
// Enables NUM_STEPS rails in order 0..N-1, one per step of D cycles, checks
// each rail's power-good at the end of its step, watches already-good rails,
// and ramps down in reverse order on request or on a power-good failure.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset; drops every rail at once
//   req       : 1 = power up / stay on, 0 = power down
//   pg        : per-rail power-good, synchronous to clk
//   rail_en   : registered thermometer-coded rail enables
//   power_ok  : all rails on and good
//   busy      : ramping up or down
//   fault     : latched power-good failure
//   fault_idx : failing rail index, valid while fault=1
// -----------------------------------------------------------------------------
module rail_power_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int NUM_STEPS  = 4,
    parameter int STEP_DELAY = 1000,
    parameter int CYCLE_TIME = 10,
    parameter int ROUND_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [NUM_STEPS-1:0] pg,
    output logic [NUM_STEPS-1:0] rail_en,
    output logic                 power_ok,
    output logic                 busy,
    output logic                 fault,
    output logic [3:0]           fault_idx
);

    localparam int DELAY_CYCLE = delay_cycles(STEP_DELAY, CYCLE_TIME, ROUND_MODE);
    localparam int SW          = $clog2(NUM_STEPS + 1);
    localparam logic [NUM_STEPS-1:0] RAIL_ONE  = NUM_STEPS'(1);
    localparam logic [SW-1:0]        STEP_ONE  = SW'(1);
    localparam logic [SW-1:0]        STEP_LAST = SW'(NUM_STEPS - 1);

    seq_state_t           state_reg;
    logic [SW-1:0]        step_reg;     // index of highest enabled rail
    logic                 start;
    logic                 done;
    logic [NUM_STEPS-1:0] step_bit;
    logic [NUM_STEPS-1:0] checked_mask;
    logic [NUM_STEPS-1:0] bad;
    logic [3:0]           fail_idx;
    logic                 chk_fail;
    logic                 fault_any;
    logic                 multi_rail;

    seq_step_timer #(
        .DELAY_CYCLE(DELAY_CYCLE)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .done (done)
    );

    always_comb begin
        step_bit = RAIL_ONE << step_reg;
        // Rails whose power-good must already be holding.
        case (state_reg)
            ST_RAMP_UP: checked_mask = step_bit - RAIL_ONE;
            ST_ON:      checked_mask = '1;
            default:    checked_mask = '0;
        endcase
        bad = checked_mask & ~pg;

        // End-of-step check names the current rail; any monitored drop has a
        // lower index and therefore takes precedence.
        fail_idx = 4'(step_reg);
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (bad[i]) begin
                fail_idx = 4'(i);
            end
        end
        chk_fail   = (state_reg == ST_RAMP_UP) && done && ((pg & step_bit) == '0);
        fault_any  = (|bad) || chk_fail;
        // More than rail 0 still on: ramp-down needs at least one more step.
        multi_rail = (rail_en >> 1) != '0;

        start = 1'b0;
        case (state_reg)
            ST_IDLE:      start = req;
            ST_RAMP_UP:   start = (fault_any || !req) ? multi_rail
                                                      : (done && (step_reg != STEP_LAST));
            ST_ON:        start = (fault_any || !req) && multi_rail;
            ST_RAMP_DOWN: start = done && multi_rail;
            default:      start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            rail_en   <= '0;
            power_ok  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            fault_idx <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        rail_en   <= RAIL_ONE;
                        step_reg  <= '0;
                        state_reg <= ST_RAMP_UP;
                        busy      <= 1'b1;
                    end
                end
                ST_RAMP_UP, ST_ON: begin
                    if (fault_any || !req) begin
                        // Fault beats a simultaneous req=0; the ramp-down
                        // itself is the same either way.
                        if (fault_any) begin
                            fault     <= 1'b1;
                            fault_idx <= fail_idx;
                        end
                        power_ok <= 1'b0;
                        rail_en  <= rail_en >> 1;
                        if (step_reg != '0) begin
                            step_reg <= step_reg - STEP_ONE;
                        end
                        if (multi_rail) begin
                            state_reg <= ST_RAMP_DOWN;
                            busy      <= 1'b1;
                        end else begin
                            state_reg <= fault_any ? ST_FAULT : ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end else if ((state_reg == ST_RAMP_UP) && done) begin
                        if (step_reg == STEP_LAST) begin
                            state_reg <= ST_ON;
                            power_ok  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            step_reg <= step_reg + STEP_ONE;
                            rail_en  <= (rail_en << 1) | RAIL_ONE;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (done) begin
                        rail_en <= rail_en >> 1;
                        if (step_reg != '0) begin
                            step_reg <= step_reg - STEP_ONE;
                        end
                        if (!multi_rail) begin
                            // Rail 0 clears on this edge.
                            state_reg <= fault ? ST_FAULT : ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (!req) begin
                        fault     <= 1'b0;
                        fault_idx <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rail_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rail_power_sequencer
// Directed bench. dut_a: N=4, D=10 with power-good following rail_en two
// cycles later (optionally masked). dut_f: STEP_DELAY=5 floor -> D=1.
// dut_c: STEP_DELAY=101 ceil -> D=11. dut_f/dut_c see all power-good high.
// -----------------------------------------------------------------------------
module tb_rail_power_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [3:0] kill = 4'b0000;
    logic [3:0] pg_d1 = 4'b0000;
    logic [3:0] pg_d2 = 4'b0000;
    logic [3:0] pg_a;
    logic [3:0] pg_b;

    logic [3:0] rail_a, rail_f, rail_c;
    logic       ok_a, ok_f, ok_c;
    logic       busy_a, busy_f, busy_c;
    logic       fault_a, fault_f, fault_c;
    logic [3:0] idx_a, idx_f, idx_c;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Rails report good two cycles after being enabled.
    always @(posedge clk) begin
        pg_d1 <= rail_a;
        pg_d2 <= pg_d1;
    end
    assign pg_a = pg_d2 & ~kill;
    assign pg_b = 4'b1111;

    rail_power_sequencer #(.NUM_STEPS(4), .STEP_DELAY(100), .CYCLE_TIME(10), .ROUND_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .pg(pg_a), .rail_en(rail_a),
        .power_ok(ok_a), .busy(busy_a), .fault(fault_a), .fault_idx(idx_a)
    );

    rail_power_sequencer #(.NUM_STEPS(4), .STEP_DELAY(5), .CYCLE_TIME(10), .ROUND_MODE(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .req(req_b), .pg(pg_b), .rail_en(rail_f),
        .power_ok(ok_f), .busy(busy_f), .fault(fault_f), .fault_idx(idx_f)
    );

    rail_power_sequencer #(.NUM_STEPS(4), .STEP_DELAY(101), .CYCLE_TIME(10), .ROUND_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_b), .pg(pg_b), .rail_en(rail_c),
        .power_ok(ok_c), .busy(busy_c), .fault(fault_c), .fault_idx(idx_c)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_rail", rail_a, 4'b0000);
        check("rst_ok", ok_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_fault", fault_a, 1'b0);
        check("rst_idx", idx_a, 4'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: full ramp-up, D=10
        req_a = 1'b1;
        tick(1);
        check("up_e0_rail", rail_a, 4'b0001);
        check("up_e0_busy", busy_a, 1'b1);
        tick(9);
        check("up_e9_rail", rail_a, 4'b0001);
        tick(1);
        check("up_e10_rail", rail_a, 4'b0011);
        tick(10);
        check("up_e20_rail", rail_a, 4'b0111);
        tick(10);
        check("up_e30_rail", rail_a, 4'b1111);
        tick(9);
        check("up_e39_ok", ok_a, 1'b0);
        check("up_e39_busy", busy_a, 1'b1);
        tick(1);
        check("up_e40_ok", ok_a, 1'b1);
        check("up_e40_busy", busy_a, 1'b0);
        tick(5);
        $display("step1 ramp-up rail=%b ok=%b", rail_a, ok_a);

        // 2: orderly ramp-down from ON
        req_a = 1'b0;
        tick(1);
        check("dn_e0_rail", rail_a, 4'b0111);
        check("dn_e0_ok", ok_a, 1'b0);
        check("dn_e0_busy", busy_a, 1'b1);
        tick(10);
        check("dn_e10_rail", rail_a, 4'b0011);
        tick(10);
        check("dn_e20_rail", rail_a, 4'b0001);
        tick(9);
        check("dn_e29_busy", busy_a, 1'b1);
        tick(1);
        check("dn_e30_rail", rail_a, 4'b0000);
        check("dn_e30_busy", busy_a, 1'b0);
        check("dn_e30_fault", fault_a, 1'b0);
        tick(2);
        $display("step2 ramp-down rail=%b busy=%b", rail_a, busy_a);

        // 3: rail 2 never goes good
        kill = 4'b0100;
        req_a = 1'b1;
        tick(1);
        check("pg2_e0_rail", rail_a, 4'b0001);
        tick(29);
        check("pg2_e29_rail", rail_a, 4'b0111);
        check("pg2_e29_fault", fault_a, 1'b0);
        tick(1);
        check("pg2_e30_fault", fault_a, 1'b1);
        check("pg2_e30_idx", idx_a, 4'd2);
        check("pg2_e30_rail", rail_a, 4'b0011);
        check("pg2_e30_busy", busy_a, 1'b1);
        tick(10);
        check("pg2_e40_rail", rail_a, 4'b0001);
        tick(10);
        check("pg2_e50_rail", rail_a, 4'b0000);
        check("pg2_e50_busy", busy_a, 1'b0);
        tick(3);
        check("pg2_hold_fault", fault_a, 1'b1);
        req_a = 1'b0;
        tick(1);
        check("pg2_clr_fault", fault_a, 1'b0);
        check("pg2_clr_idx", idx_a, 4'd0);
        kill = 4'b0000;
        tick(2);
        $display("step3 pg2 fault cleared fault=%b", fault_a);

        // 4: one-cycle pg[1] glitch while ON
        req_a = 1'b1;
        tick(41);
        check("gl_on_ok", ok_a, 1'b1);
        tick(3);
        kill = 4'b0010;
        tick(1);
        kill = 4'b0000;
        check("gl_fault", fault_a, 1'b1);
        check("gl_idx", idx_a, 4'd1);
        check("gl_ok", ok_a, 1'b0);
        check("gl_rail0", rail_a, 4'b0111);
        tick(10);
        check("gl_rail1", rail_a, 4'b0011);
        tick(10);
        check("gl_rail2", rail_a, 4'b0001);
        tick(10);
        check("gl_rail3", rail_a, 4'b0000);
        tick(5);
        check("gl_hold_fault", fault_a, 1'b1);
        check("gl_hold_rail", rail_a, 4'b0000);
        req_a = 1'b0;
        tick(1);
        check("gl_clr_fault", fault_a, 1'b0);
        tick(2);
        $display("step4 glitch fault cleared fault=%b", fault_a);

        // 5: abort mid-ramp, req re-raised during ramp-down
        req_a = 1'b1;
        tick(1);
        check("ab_e0_rail", rail_a, 4'b0001);
        tick(14);
        check("ab_e14_rail", rail_a, 4'b0011);
        req_a = 1'b0;
        tick(1);
        check("ab_e15_rail", rail_a, 4'b0001);
        check("ab_e15_busy", busy_a, 1'b1);
        tick(1);
        req_a = 1'b1;
        tick(8);
        check("ab_e24_rail", rail_a, 4'b0001);
        tick(1);
        check("ab_e25_rail", rail_a, 4'b0000);
        check("ab_e25_busy", busy_a, 1'b0);
        tick(1);
        check("ab_e26_rail", rail_a, 4'b0001);
        check("ab_e26_busy", busy_a, 1'b1);
        $display("step5 abort and restart rail=%b", rail_a);

        // 6: D=1 (floor) and D=11 (ceil), then async reset mid-ramp
        req_b = 1'b1;
        tick(1);
        check("f_e0_rail", rail_f, 4'b0001);
        check("c_e0_rail", rail_c, 4'b0001);
        tick(1);
        check("f_e1_rail", rail_f, 4'b0011);
        tick(2);
        check("f_e3_rail", rail_f, 4'b1111);
        check("f_e3_ok", ok_f, 1'b0);
        tick(1);
        check("f_e4_ok", ok_f, 1'b1);
        check("c_e4_rail", rail_c, 4'b0001);
        tick(6);
        check("c_e10_rail", rail_c, 4'b0001);
        tick(1);
        check("c_e11_rail", rail_c, 4'b0011);
        tick(11);
        check("c_e22_rail", rail_c, 4'b0111);
        rst_n = 1'b0;
        #2;
        check("ar_c_rail", rail_c, 4'b0000);
        check("ar_c_busy", busy_c, 1'b0);
        check("ar_f_ok", ok_f, 1'b0);
        check("ar_a_rail", rail_a, 4'b0000);
        check("ar_a_busy", busy_a, 1'b0);
        $display("step6 timing variants and async reset rail_c=%b ok_f=%b", rail_c, ok_f);
        tick(2);
        rst_n = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
